// File: rtl/uart_transceiver_if.sv
// Parallel-side bus of the UART transceiver: transmit request/data in, received byte and status out.
// The master drives transmit requests. The slave is the transceiver itself.
interface uart_transceiver_if #(
   parameter int SIZE = 8
);
   logic [SIZE-1:0] tx_data;
   logic            tx_rq;
   logic            tx_busy;
   logic [SIZE-1:0] dq;
   logic            rx_ready;
   logic            frame_error;

   modport master (
      output tx_data, tx_rq,
      input  tx_busy, dq, rx_ready, frame_error
   );

   modport slave (
      input  tx_data, tx_rq,
      output tx_busy, dq, rx_ready, frame_error
   );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1-style UART. An independent TX serialiser and a mid-bit-sampling RX deserialiser
// share one clock and an internal bit-rate divider.
module uart_transceiver #(
   parameter int SIZE         = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_transceiver_if.slave        bus,
   output logic                     txd,
   input  logic                     rxd
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(SIZE);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_BREAK = 3'd4;

   logic [1:0]      tx_state_reg;
   logic [CW-1:0]   tx_cnt_reg;
   logic [BW-1:0]   tx_bit_reg;
   logic [SIZE-1:0] tx_shift_reg;
   logic            txd_reg;

   logic [1:0]      rx_sync_reg;
   logic [2:0]      rx_state_reg;
   logic [CW-1:0]   rx_cnt_reg;
   logic [BW-1:0]   rx_bit_reg;
   logic [SIZE-1:0] rx_shift_reg;
   logic [SIZE-1:0] dq_reg;
   logic            rx_ready_reg;
   logic            frame_error_reg;
   logic            rx_s;

   // ---------------- transmitter ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         txd_reg      <= 1'b1;
      end else begin
         case (tx_state_reg)
            TX_IDLE: begin
               if (bus.tx_rq) begin
                  tx_shift_reg <= bus.tx_data;
                  tx_cnt_reg   <= '0;
                  tx_bit_reg   <= '0;
                  txd_reg      <= 1'b0;
                  tx_state_reg <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_reg == BIT_END) begin
                  tx_cnt_reg   <= '0;
                  txd_reg      <= tx_shift_reg[0];
                  tx_state_reg <= TX_DATA;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_reg == BIT_END) begin
                  tx_cnt_reg <= '0;
                  if (tx_bit_reg == LAST_BIT) begin
                     txd_reg      <= 1'b1;
                     tx_state_reg <= TX_STOP;
                  end else begin
                     // Look one bit ahead so TXD changes on the same edge as the shift.
                     tx_bit_reg   <= tx_bit_reg + 1'b1;
                     tx_shift_reg <= {1'b0, tx_shift_reg[SIZE-1:1]};
                     txd_reg      <= tx_shift_reg[1];
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_reg == BIT_END) begin
                  tx_cnt_reg   <= '0;
                  tx_state_reg <= TX_IDLE;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            default: tx_state_reg <= TX_IDLE;
         endcase
      end
   end

   assign txd         = txd_reg;
   assign bus.tx_busy = (tx_state_reg != TX_IDLE);

   // ---------------- receiver ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_sync_reg <= 2'b11;
      end else begin
         rx_sync_reg <= {rx_sync_reg[0], rxd};
      end
   end

   assign rx_s = rx_sync_reg[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_reg    <= RX_IDLE;
         rx_cnt_reg      <= '0;
         rx_bit_reg      <= '0;
         rx_shift_reg    <= '0;
         dq_reg          <= '0;
         rx_ready_reg    <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         rx_ready_reg <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_cnt_reg   <= '0;
                  rx_state_reg <= RX_START;
               end
            end
            RX_START: begin
               // Half-bit check rejects short low glitches and centres later samples.
               if (rx_cnt_reg == HALF_END) begin
                  rx_cnt_reg   <= '0;
                  rx_bit_reg   <= '0;
                  rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_reg == BIT_END) begin
                  rx_cnt_reg   <= '0;
                  rx_shift_reg <= {rx_s, rx_shift_reg[SIZE-1:1]};
                  rx_bit_reg   <= rx_bit_reg + 1'b1;
                  if (rx_bit_reg == LAST_BIT) begin
                     rx_state_reg <= RX_STOP;
                  end
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_reg == BIT_END) begin
                  rx_cnt_reg      <= '0;
                  dq_reg          <= rx_shift_reg;
                  rx_ready_reg    <= 1'b1;
                  frame_error_reg <= ~rx_s;
                  rx_state_reg    <= rx_s ? RX_IDLE : RX_BREAK;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 1'b1;
               end
            end
            RX_BREAK: begin
               // A held-low line must return high before a new start bit is recognised.
               if (rx_s) begin
                  rx_state_reg <= RX_IDLE;
               end
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   assign bus.dq          = dq_reg;
   assign bus.rx_ready    = rx_ready_reg;
   assign bus.frame_error = frame_error_reg;
endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: loopback and directly driven frames, with a queue-based
// receive scoreboard and an expected frame built from start/data/stop arithmetic.
module tb_uart_transceiver;
   localparam int SIZE      = 8;
   localparam int CPB       = 16;
   localparam int FRAME_CYC = (SIZE + 2) * CPB;
   localparam int LAT_MIN   = (SIZE + 1) * CPB + CPB / 2 + 2;
   localparam int LAT_MAX   = (SIZE + 1) * CPB + CPB / 2 + 3;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      logic       timed;
      int         t0;
   } exp_t;

   logic clk;
   logic rst_n;
   logic txd;
   logic rxd;
   logic rxd_drv;
   logic loop_en;
   int   cyc;
   int   checks;
   int   errors;
   exp_t exp_q[$];
   exp_t mon_e;
   int   mon_lat;

   uart_transceiver_if #(.SIZE(SIZE)) bus ();

   uart_transceiver #(.SIZE(SIZE), .CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .txd   (txd),
      .rxd   (rxd)
   );

   assign rxd = loop_en ? txd : rxd_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Receive scoreboard: every RX_READY strobe must match the oldest outstanding frame.
   always @(negedge clk) begin
      if (bus.rx_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("rx_spurious_ready", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            $display("rx frame: dq=0x%02h ferr=%0b (expected 0x%02h ferr=%0b)",
                     bus.dq, bus.frame_error, mon_e.data, mon_e.ferr);
            check_eq("rx_dq", bus.dq, mon_e.data);
            check_eq("rx_frame_error", bus.frame_error, mon_e.ferr);
            if (mon_e.timed) begin
               mon_lat = cyc - mon_e.t0;
               check_eq("rx_latency_in_window", (mon_lat >= LAT_MIN && mon_lat <= LAT_MAX), 1);
            end
         end
      end
   end

   // Send one byte in loopback. Optionally pulse a second request mid-frame (inject_at >= 0).
   task automatic tx_frame(input logic [7:0] b, input int inject_at);
      int         n;
      int         bad;
      logic [9:0] frame;
      logic [9:0] seen;
      exp_t       e;
      n = 0;
      while (bus.tx_busy && n < 2 * FRAME_CYC) begin
         @(negedge clk);
         n++;
      end
      check_eq("tx_idle_before_rq", bus.tx_busy, 0);
      frame = {1'b1, b, 1'b0};
      bus.tx_data = b;
      bus.tx_rq   = 1'b1;
      @(negedge clk);
      bus.tx_rq = 1'b0;
      e.data = b; e.ferr = 1'b0; e.timed = 1'b1; e.t0 = cyc;
      exp_q.push_back(e);
      n = 0; bad = 0; seen = '0;
      while (bus.tx_busy && n < 2 * FRAME_CYC) begin
         if (n / CPB < 10) begin
            if (txd !== frame[n / CPB]) bad++;
            if (n % CPB == CPB / 2) seen[n / CPB] = txd;
         end else begin
            bad++;
         end
         if (n == inject_at) begin
            bus.tx_data = 8'h3C;
            bus.tx_rq   = 1'b1;
         end else if (n == inject_at + 1) begin
            bus.tx_rq = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      $display("tx frame: data=0x%02h busy=%0d cycles bits=%b", b, n, seen);
      check_eq("tx_busy_cycles", n, FRAME_CYC);
      check_eq("tx_bit_sequence", seen, frame);
      check_eq("tx_line_stable", bad, 0);
      check_eq("tx_idle_line", txd, 1);
   endtask

   // Drive a frame straight onto RXD; a low stop bit is followed by one extra low bit time.
   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      exp_t       e;
      frame = {stop, b, 1'b0};
      e.data = b; e.ferr = ~stop; e.timed = 1'b0; e.t0 = 0;
      exp_q.push_back(e);
      for (int k = 0; k < 10; k++) begin
         rxd_drv = frame[k];
         repeat (CPB) @(negedge clk);
      end
      if (!stop) repeat (CPB) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4 * FRAME_CYC) begin
         @(negedge clk);
         n++;
      end
      check_eq("rx_all_frames_seen", exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] rb;
      checks = 0; errors = 0;
      rst_n = 1'b0; loop_en = 1'b1; rxd_drv = 1'b1;
      bus.tx_data = '0; bus.tx_rq = 1'b0;

      repeat (50) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: txd=%0b busy=%0b ready=%0b dq=0x%02h ferr=%0b",
               txd, bus.tx_busy, bus.rx_ready, bus.dq, bus.frame_error);
      check_eq("reset_txd", txd, 1);
      check_eq("reset_tx_busy", bus.tx_busy, 0);
      check_eq("reset_rx_ready", bus.rx_ready, 0);
      check_eq("reset_dq", bus.dq, 0);
      check_eq("reset_frame_error", bus.frame_error, 0);

      tx_frame(8'hA5, -1);
      drain();

      // Back-to-back: the second request lands on the cycle TX_BUSY falls.
      tx_frame(8'h00, -1);
      tx_frame(8'hFF, -1);
      drain();

      // A request mid-frame with different data must be ignored.
      tx_frame(8'h5A, 40);
      repeat (3) @(negedge clk);
      check_eq("tx_rq_ignored_while_busy", bus.tx_busy, 0);
      drain();

      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom_range(0, 255));
         tx_frame(rb, -1);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      drain();

      // Directly driven RXD: framing error, recovery, then a short glitch.
      loop_en = 1'b0;
      rx_frame(8'h81, 1'b0);
      rx_frame(8'h42, 1'b1);
      drain();
      rxd_drv = 1'b0;
      repeat (3) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check_eq("glitch_dq_held", bus.dq, 8'h42);
      check_eq("glitch_ferr_held", bus.frame_error, 0);
      for (int i = 0; i < 3; i++) begin
         rx_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      drain();
      loop_en = 1'b1;

      // One-cycle reset mid-frame aborts both directions.
      bus.tx_data = 8'h77;
      bus.tx_rq   = 1'b1;
      @(negedge clk);
      bus.tx_rq = 1'b0;
      repeat (60) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("mid-frame reset: txd=%0b busy=%0b", txd, bus.tx_busy);
      check_eq("abort_txd", txd, 1);
      check_eq("abort_tx_busy", bus.tx_busy, 0);
      check_eq("abort_dq", bus.dq, 0);
      repeat (2 * FRAME_CYC) @(negedge clk);
      tx_frame(8'h96, -1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART transmitter plus receiver in one synchronous block, clocked by a single system clock.
- The bit rate is derived internally from a clock divider.
- The transmit side serialises a parallel byte onto TXD on request.
- The receive side deserialises RXD, presents the byte on DQ with a one-cycle RX_READY strobe and flags bad stop bits. In system test TXD is looped to RXD externally.

Parameters:
- SIZE, 8, data bits per frame (frame = 1 start + SIZE data + 1 stop); legal range 5..9.
- CLKS_PER_BIT, 16, CLK cycles per serial bit; must be an even value >= 4.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset), sampled on rising CLK.
- TXDATA  input  SIZE  byte to transmit; sampled only when a request is accepted.
- TX_RQ  input  1  transmit request; a single-cycle pulse is sufficient.
- TX_BUSY  output  1  high while a frame is being transmitted.
- TXD  output  1  serial transmit line; idle high.
- RXD  input  1  serial receive line; asynchronous, idle high.
- DQ  output  SIZE  last received byte; held until the next frame completes.
- RX_READY  output  1  one-cycle strobe when DQ is updated.
- FRAME_ERROR  output  1  stop bit of the last frame sampled low; valid with RX_READY and held until the next frame completes.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - Outputs next cycle: TXD=1, TX_BUSY=0, DQ=0, RX_READY=0, FRAME_ERROR=0.
  - Both FSMs return to IDLE, all counters clear, synchroniser flops are set to 1.
  - Reset mid-frame aborts the frame immediately. No partial byte is delivered.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: TXD=1, TX_BUSY=0. TX_RQ=1 at an edge latches TXDATA into a shift register. The next cycle gives TX_BUSY=1 and TXD=0.
  - START: TXD=0 for CLKS_PER_BIT cycles.
  - DATA: SIZE bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: TXD=1 for CLKS_PER_BIT cycles, then IDLE with TX_BUSY=0.
  - TX_BUSY is high for exactly (SIZE+2)*CLKS_PER_BIT cycles.
  - TX_RQ while TX_BUSY=1 is ignored (no queueing).
  - TX_RQ asserted on the very cycle TX_BUSY falls is accepted.
  - TXDATA changes while busy do not affect the frame.
- RX synchroniser: RXD passes through 2 flops; all decisions use the synchronised value.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: synchronised RXD=0 enters START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 1, treat as a glitch and return to IDLE with no outputs changed. If 0, enter DATA.
  - DATA: sample at every CLKS_PER_BIT interval (mid-bit), shifting LSB first, SIZE samples.
  - STOP: sample one CLKS_PER_BIT later. On that cycle DQ<=shift register, RX_READY<=1 (exactly one cycle), FRAME_ERROR<=~sample.
    - If the stop bit was 1, go to IDLE immediately. This allows back-to-back frames with no idle gap.
    - If the stop bit was 0, wait until synchronised RXD=1 before IDLE (no false restart on a break).
- RX_READY is 0 at all other times. DQ and FRAME_ERROR change only on the RX_READY cycle.
- Latency: from the first TXD=0 cycle (looped to RXD), RX_READY asserts (SIZE+1)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 2..3 cycles later.
- TX and RX are fully independent. Simultaneous transmit and receive is required.

Test Plan:
- Reset: hold RESET=0 for 50 cycles, release -> TXD=1, TX_BUSY=0, RX_READY=0, DQ=0x00, FRAME_ERROR=0.
- Loopback TXD->RXD, TXDATA=0xA5 with a 1-cycle TX_RQ:
  - TXD bit sequence (per CLKS_PER_BIT) must be 0,1,0,1,0,0,1,0,1,1.
  - TX_BUSY high for 160 cycles.
  - One RX_READY pulse with DQ=0xA5, FRAME_ERROR=0, inside the latency window.
- Back-to-back: send 0x00, then 0xFF with TX_RQ on the cycle TX_BUSY falls -> two RX_READY pulses with DQ=0x00 then 0xFF, no gap error.
- TX_RQ pulsed with TXDATA=0x3C mid-frame of 0x5A -> ignored; only 0x5A is received.
- RXD driven directly:
  - Valid frame 0x81 with stop bit 0 -> RX_READY pulse, DQ=0x81, FRAME_ERROR=1.
  - Next good frame 0x42 -> FRAME_ERROR=0.
  - A low glitch of 3 cycles produces no RX_READY.
- RESET=0 for 1 cycle mid-frame -> TXD=1 and TX_BUSY=0 next cycle; no RX_READY for the aborted frame; the following 0x96 frame is received correctly.
